// File: rtl/hazard_ctrl_pipe.sv
// hazard_ctrl_pipe: pipeline hazard controller for load-use, load latency, mispredict and interrupt entry
module hazard_ctrl_pipe #(
  parameter int XLEN      = 32,
  parameter int RA_W      = 5,
  parameter int LOAD_LAT  = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [RA_W-1:0] i_id_rs1_addr,
  input  logic [RA_W-1:0] i_id_rs2_addr,
  input  logic            i_id_use_rs1,
  input  logic            i_id_use_rs2,
  input  logic [RA_W-1:0] i_ex_rd_addr,
  input  logic [RA_W-1:0] i_mem_rd_addr,
  input  logic [RA_W-1:0] i_wb_rd_addr,
  input  logic            i_ex_rd_wren,
  input  logic            i_mem_rd_wren,
  input  logic            i_wb_rd_wren,
  input  logic            i_ex_is_load,
  input  logic            i_mem_is_load,
  input  logic            i_ex_is_ctrl,
  input  logic            i_ex_taken,
  input  logic [XLEN-1:0] i_ex_target,
  input  logic            i_ex_pred_taken,
  input  logic [XLEN-1:0] i_ex_pred_target,
  input  logic            i_intr_req,
  input  logic            i_intr_en,
  output logic            o_pc_en,
  output logic            o_stall_id,
  output logic            o_stall_ex,
  output logic            o_stall_mem,
  output logic            o_flush_id,
  output logic            o_flush_ex,
  output logic            o_flush_wb,
  output logic            o_redirect,
  output logic            o_intr_ack,
  output logic [1:0]      o_state,
  output logic [15:0]     o_mispred_cnt
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, INT_DRAIN = 2'd2} state_e;
  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wait_done_q, wait_done_d;
  logic [15:0] mispred_cnt_q, mispred_cnt_d;
  logic        match_ex, match_wb, loaduse, mispred, memwait, intr_ok;
  logic        unused_mem;
  assign unused_mem = ^{i_mem_rd_addr, i_mem_rd_wren};
  assign match_ex = i_ex_rd_wren && i_ex_rd_addr != '0 &&
                    ((i_ex_rd_addr == i_id_rs1_addr && i_id_use_rs1) || (i_ex_rd_addr == i_id_rs2_addr && i_id_use_rs2));
  assign match_wb = i_wb_rd_wren && i_wb_rd_addr != '0 &&
                    ((i_wb_rd_addr == i_id_rs1_addr && i_id_use_rs1) || (i_wb_rd_addr == i_id_rs2_addr && i_id_use_rs2));
  assign loaduse = (match_ex && i_ex_is_load) || (WB_BYPASS == 0 && match_wb);
  assign mispred = i_ex_is_ctrl && (i_ex_taken != i_ex_pred_taken || (i_ex_taken && i_ex_target != i_ex_pred_target));
  assign memwait = i_mem_is_load && LOAD_LAT != 0 && !wait_done_q;
  assign intr_ok = i_intr_req && i_intr_en && !i_ex_is_ctrl && !i_ex_is_load && !i_mem_is_load;
  assign o_state = state_q;
  assign o_mispred_cnt = mispred_cnt_q;
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wait_done_d   = wait_done_q;
    mispred_cnt_d = mispred_cnt_q;
    o_pc_en       = 1'b1;
    o_stall_id    = 1'b0;
    o_stall_ex    = 1'b0;
    o_stall_mem   = 1'b0;
    o_flush_id    = 1'b0;
    o_flush_ex    = 1'b0;
    o_flush_wb    = 1'b0;
    o_redirect    = 1'b0;
    o_intr_ack    = 1'b0;
    case (state_q)
      RUN: begin
        if (memwait) begin
          {o_pc_en, o_stall_id, o_stall_ex, o_stall_mem, o_flush_wb} = 5'b01111;
          if (LOAD_LAT == 1) begin
            wait_done_d = 1'b1;
          end else begin
            state_d = MEM_WAIT;
            cnt_d   = 3'(LOAD_LAT - 1);
          end
        end else begin
          wait_done_d = 1'b0;
          if (mispred) begin
            {o_redirect, o_flush_id, o_flush_ex} = 3'b111;
            mispred_cnt_d = mispred_cnt_q + {15'd0, mispred_cnt_q != 16'hFFFF};
          end else if (loaduse) begin
            {o_pc_en, o_stall_id, o_flush_ex} = 3'b011;
          end else if (intr_ok) begin
            {o_pc_en, o_flush_id} = 2'b01;
            cnt_d   = 3'd2;
            state_d = INT_DRAIN;
          end
        end
      end
      MEM_WAIT: begin
        {o_pc_en, o_stall_id, o_stall_ex, o_stall_mem, o_flush_wb} = 5'b01111;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d     = RUN;
          wait_done_d = 1'b1;
        end
      end
      INT_DRAIN: begin
        {o_pc_en, o_flush_id} = 2'b01;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          o_intr_ack = 1'b1;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // reset overrides everything so no ack or stall escapes an aborted sequence
    if (i_reset) begin
      {o_pc_en, o_stall_id, o_stall_ex, o_stall_mem} = 4'b0000;
      {o_flush_id, o_flush_ex, o_flush_wb, o_redirect, o_intr_ack} = 5'b11100;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      wait_done_q   <= 1'b0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wait_done_q   <= wait_done_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// tb_hazard_ctrl_pipe: three parameterisations driven in lockstep against a remaining-cycles reference model
module tb_hazard_ctrl_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, use1, use2, exw, memw, wbw, exld, memld, exctrl, taken, ptaken, ireq, ien;
  logic [4:0]  rs1, rs2, exrd, memrd, wbrd;
  logic [31:0] target, ptarget;
  logic [2:0]  pc_en, sid, sex, smem, fid, fex, fwb, red, ack;
  logic [1:0]  st [3];
  logic [15:0] mc [3];
  int checks = 0, failures = 0;
  int lat [3] = '{3, 0, 1};
  bit byp [3] = '{1'b1, 1'b0, 1'b1};
  int mw_left [3], dr_left [3], mcnt [3];
  bit done [3];
  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      hazard_ctrl_pipe #(.LOAD_LAT(g == 0 ? 3 : g == 1 ? 0 : 1), .WB_BYPASS(g == 1 ? 0 : 1)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
        .i_ex_rd_addr(exrd), .i_mem_rd_addr(memrd), .i_wb_rd_addr(wbrd),
        .i_ex_rd_wren(exw), .i_mem_rd_wren(memw), .i_wb_rd_wren(wbw),
        .i_ex_is_load(exld), .i_mem_is_load(memld), .i_ex_is_ctrl(exctrl),
        .i_ex_taken(taken), .i_ex_target(target), .i_ex_pred_taken(ptaken), .i_ex_pred_target(ptarget),
        .i_intr_req(ireq), .i_intr_en(ien),
        .o_pc_en(pc_en[g]), .o_stall_id(sid[g]), .o_stall_ex(sex[g]), .o_stall_mem(smem[g]),
        .o_flush_id(fid[g]), .o_flush_ex(fex[g]), .o_flush_wb(fwb[g]), .o_redirect(red[g]),
        .o_intr_ack(ack[g]), .o_state(st[g]), .o_mispred_cnt(mc[g]));
    end
  endgenerate
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic quiet();
    {rst, use1, use2, exw, memw, wbw, exld, memld, exctrl, taken, ptaken, ireq, ien} = '0;
    {rs1, rs2, exrd, memrd, wbrd} = '0;
    target = 32'h100;
    ptarget = 32'h100;
  endtask
  // expected vector order: pc_en stall_id stall_ex stall_mem flush_id flush_ex flush_wb redirect intr_ack
  task automatic step(input bit chk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      logic [8:0]  e;
      logic [1:0]  es;
      logic [15:0] emc;
      bit mex, mwb, lu, mp, mw;
      mex = exw && exrd != 0 && ((exrd == rs1 && use1) || (exrd == rs2 && use2));
      mwb = wbw && wbrd != 0 && ((wbrd == rs1 && use1) || (wbrd == rs2 && use2));
      lu  = (mex && exld) || (!byp[k] && mwb);
      mp  = exctrl && (taken != ptaken || (taken && target != ptarget));
      mw  = memld && lat[k] != 0 && !done[k];
      es  = mw_left[k] > 0 ? 2'd1 : dr_left[k] > 0 ? 2'd2 : 2'd0;
      emc = 16'(mcnt[k]);
      if (rst) begin
        e = 9'b0_000_111_00;
        mw_left[k] = 0; dr_left[k] = 0; done[k] = 0; mcnt[k] = 0;
      end else if (mw_left[k] > 0) begin
        e = 9'b0_111_001_00;
        mw_left[k]--;
        if (mw_left[k] == 0) done[k] = 1;
      end else if (dr_left[k] > 0) begin
        e = {1'b0, 3'b000, 3'b100, 1'b0, dr_left[k] == 1};
        dr_left[k]--;
      end else if (mw) begin
        e = 9'b0_111_001_00;
        mw_left[k] = lat[k] - 1;
        done[k] = (lat[k] == 1);
      end else begin
        done[k] = 0;
        if (mp) begin
          e = 9'b1_000_110_10;
          if (mcnt[k] < 65535) mcnt[k]++;
        end else if (lu) e = 9'b0_100_010_00;
        else if (ireq && ien && !exctrl && !exld && !memld) begin
          e = 9'b0_000_100_00;
          dr_left[k] = 2;
        end else e = 9'b1_000_000_00;
      end
      if (chk) begin
        check($sformatf("outs%0d", k),
              {21'd0, pc_en[k], sid[k], sex[k], smem[k], fid[k], fex[k], fwb[k], red[k], ack[k], st[k]}, {21'd0, e, es});
        check($sformatf("mcnt%0d", k), {16'd0, mc[k]}, {16'd0, emc});
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    quiet();
    rst = 1'b1;
    step(0);
    step(1);
    rst = 1'b0;
    ireq = 1'b1;
    repeat (2) step(1);
    ien = 1'b1;
    repeat (4) step(1);
    quiet();
    memld = 1'b1;
    repeat (6) step(1);
    quiet();
    {exw, exld, exrd, rs1, use1} = {1'b1, 1'b1, 5'd5, 5'd5, 1'b1};
    {exctrl, ptaken, taken, target, ptarget} = {1'b1, 1'b1, 1'b1, 32'h100, 32'h104};
    step(1);
    exctrl = 1'b0;
    repeat (2) step(1);
    quiet();
    memld = 1'b1;
    step(1);
    {exctrl, taken} = 2'b11;
    repeat (4) step(1);
    for (int i = 0; i < 3000; i++) begin
      rst    = $urandom_range(63) == 0;
      rs1    = 5'($urandom_range(3));
      rs2    = 5'($urandom_range(3));
      exrd   = 5'($urandom_range(3));
      memrd  = 5'($urandom_range(3));
      wbrd   = 5'($urandom_range(3));
      {use1, use2, exw, memw, wbw} = 5'($urandom);
      exld   = $urandom_range(3) == 0;
      memld  = $urandom_range(4) == 0;
      exctrl = $urandom_range(3) == 0;
      taken  = 1'($urandom);
      ptaken = 1'($urandom);
      target = $urandom_range(1) ? 32'h100 : 32'h104;
      ptarget = $urandom_range(1) ? 32'h100 : 32'h104;
      ireq   = $urandom_range(1) == 0;
      ien    = $urandom_range(9) < 7;
      step(1);
    end
    quiet();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    {exctrl, ptaken} = 2'b11;
    for (int i = 0; i < 65540; i++) step(0);
    step(1);
    quiet();
    {ireq, ien} = 2'b11;
    step(1);
    ireq = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    repeat (3) step(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_pipe.md
HAZARD_CTRL_PIPE -- requirements
Module: hazard_ctrl_pipe

Interface
REQ-001 Parameters SHALL be:
- XLEN, default 32, PC/target width.
- RA_W, default 5, register address width.
- LOAD_LAT, default 2, extra data-memory stall cycles per load, legal range 0..7.
- WB_BYPASS, default 1; 1 means a WB->ID bypass exists, 0 means a WB match stalls.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be (name  direction  width  meaning):
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_id_rs1_addr, i_id_rs2_addr  in  RA_W  ID source registers.
- i_id_use_rs1, i_id_use_rs2  in  1  ID actually reads that source.
- i_ex_rd_addr, i_mem_rd_addr, i_wb_rd_addr  in  RA_W  destination registers.
- i_ex_rd_wren, i_mem_rd_wren, i_wb_rd_wren  in  1  destination write enables.
- i_ex_is_load, i_mem_is_load  in  1  stage holds a load.
- i_ex_is_ctrl  in  1  EX holds branch/JAL/JALR.
- i_ex_taken  in  1  resolved direction.
- i_ex_target  in  XLEN  resolved target.
- i_ex_pred_taken  in  1  BTB prediction carried to EX.
- i_ex_pred_target  in  XLEN  predicted target.
- i_intr_req, i_intr_en  in  1  interrupt request and global enable.
- o_pc_en  out  1  PC may update.
- o_stall_id, o_stall_ex, o_stall_mem  out  1  hold the stage register (active-high).
- o_flush_id, o_flush_ex, o_flush_wb  out  1  load a bubble into the stage register (active-high).
- o_redirect  out  1  PC takes the resolved EX target.
- o_intr_ack  out  1  one-cycle interrupt-entry pulse.
- o_state  out  2  FSM state.
- o_mispred_cnt  out  16  saturating mispredict count.

Function
REQ-004 The FSM SHALL have three states: RUN=0, MEM_WAIT=1, INT_DRAIN=2; o_state SHALL equal the state register.
REQ-005 Default outputs SHALL be: o_pc_en=1; all other outputs 0.
REQ-006 Terms SHALL be defined as:
- match(x) = x_wren && x_addr!=0 && ((x_addr==rs1 && use_rs1) || (x_addr==rs2 && use_rs2)).
- loaduse = match(ex) && i_ex_is_load, OR (WB_BYPASS==0 && match(wb)).
- mispred = i_ex_is_ctrl && (i_ex_taken!=i_ex_pred_taken || (i_ex_taken && i_ex_target!=i_ex_pred_target)).
- memwait = i_mem_is_load && LOAD_LAT!=0 && !wait_done.
REQ-007 In RUN, conditions SHALL be evaluated in strict priority order: memwait > mispred > loaduse > interrupt.
REQ-008 On memwait in RUN:
- Outputs: o_pc_en=0, o_stall_id=o_stall_ex=o_stall_mem=1, o_flush_wb=1.
- If LOAD_LAT==1, stay in RUN and set wait_done.
- Otherwise go to MEM_WAIT with cnt<=LOAD_LAT-1.
REQ-009 In MEM_WAIT:
- Outputs SHALL match REQ-008; cnt SHALL decrement each cycle.
- When cnt==1, go to RUN and set wait_done.
- Total stall SHALL be exactly LOAD_LAT cycles per load.
REQ-010 wait_done SHALL clear on any RUN cycle with o_stall_mem=0.
REQ-011 mispred SHALL be ignored outside RUN; EX is frozen, so mispred is re-evaluated on return to RUN.
REQ-012 On mispred in RUN: o_redirect=1, o_flush_id=o_flush_ex=1, o_pc_en=1, and o_mispred_cnt SHALL increment, saturating at 16'hFFFF.
REQ-013 On loaduse in RUN (no mispred): o_pc_en=0, o_stall_id=1, o_flush_ex=1, for one cycle per evaluation; it re-evaluates every cycle.
REQ-014 Interrupt entry in RUN SHALL require all of:
- i_intr_req && i_intr_en;
- none of memwait, mispred, loaduse;
- !i_ex_is_ctrl && !i_ex_is_load && !i_mem_is_load.
REQ-015 On interrupt entry: o_pc_en=0, o_flush_id=1, cnt<=2, go to INT_DRAIN.
REQ-016 In INT_DRAIN:
- o_pc_en=0, o_flush_id=1, and cnt SHALL decrement.
- When cnt==1: o_intr_ack=1 and go to RUN.
- Entry-to-ack latency SHALL be 2 cycles.
- INT_DRAIN is non-preemptible.
- i_intr_req deassert mid-drain SHALL NOT abort the drain.
REQ-017 o_intr_ack SHALL be high for exactly one cycle per entry.
REQ-018 o_stall_* and o_flush_* of the same stage SHALL never both be 1.

Reset
REQ-019 While i_reset=1, the block SHALL drive: o_pc_en=0, o_flush_id=o_flush_ex=o_flush_wb=1, all stalls 0, o_redirect=0, o_intr_ack=0.
REQ-020 At the first edge with i_reset=1, registers SHALL load: state=RUN, cnt=0, wait_done=0, o_mispred_cnt=0.
REQ-021 Reset asserted in MEM_WAIT or INT_DRAIN SHALL abort the sequence with no o_intr_ack.

Verification
REQ-022 Load-use, LOAD_LAT=0: EX load rd=5, ID rs1=5 used -> one cycle o_pc_en=0, o_stall_id=1, o_flush_ex=1; next cycle defaults.
REQ-023 Memory wait, LOAD_LAT=3: load reaches MEM -> exactly 3 cycles of stall_id/ex/mem=1 with o_flush_wb=1, o_state 0,1,1 -> 0, then the load advances.
REQ-024 Mispredict: i_ex_pred_taken=1, i_ex_taken=1, target 0x100 vs predicted 0x104 -> o_redirect=1, flush ID/EX, o_mispred_cnt 0->1; a simultaneous loaduse is masked.
REQ-025 Interrupt: i_intr_req=i_intr_en=1 in a quiet pipeline -> INT_DRAIN for 2 cycles, o_intr_ack pulse on cycle 2, return to RUN; with i_intr_en=0 -> no response.
REQ-026 Collision: mispred during MEM_WAIT (LOAD_LAT=2) -> o_redirect stays 0 until RUN, then asserts for one cycle.
REQ-027 Reset mid-INT_DRAIN -> o_state=0, no o_intr_ack; counter saturation: 65536 mispredicts -> o_mispred_cnt holds 16'hFFFF.
